ins_fetch: RTL
==============

INS_FETCH -- requirements
Module: ins_fetch

Interface
REQ-001 SHALL have parameter DEPTH, default 8, the number of 32-bit instruction words; the address width is 3 bits.
REQ-002 SHALL have parameter MAX_FETCH, default 15, the fetch limit per run (loop guard).
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: begin a fetch run at word 0.
REQ-006 SHALL have port ld_en, input, 1 bit: program-load write strobe.
REQ-007 SHALL have port ld_addr, input, 3 bits: program-load word index.
REQ-008 SHALL have port ld_data, input, 32 bits: program-load word.
REQ-009 SHALL have port out_valid, output, 1 bit: out_instr/out_pc hold a fetched word.
REQ-010 SHALL have port out_ready, input, 1 bit: the downstream decode/count stage accepts the word.
REQ-011 SHALL have port out_instr, output, 32 bits: fetched instruction.
REQ-012 SHALL have port out_pc, output, 3 bits: word index of out_instr.
REQ-013 SHALL have port fetch_count, output, 4 bits: words fetched this run.
REQ-014 SHALL have port done, output, 1 bit: run complete, all words accepted.

Function
REQ-015 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-016 SHALL, in IDLE, write ld_data into word ld_addr on a clk edge with ld_en=1; ld_en SHALL be ignored in RUN and DONE.
REQ-017 SHALL, on start=1 in IDLE or DONE, go to RUN with pc=0, fetch_count=0 and done=0; if start and ld_en occur together in IDLE, the write SHALL complete and RUN SHALL be entered.
REQ-018 SHALL treat the output slot as free when out_valid=0, or when out_valid=1 and out_ready=1.
REQ-019 SHALL, in RUN with a free slot and the end flag clear, load out_instr=mem[pc] and out_pc=pc, set out_valid=1, and increment fetch_count, all on the same edge.
REQ-020 SHALL hold out_instr, out_pc and out_valid stable while out_valid=1 and out_ready=0.
REQ-021 SHALL sustain one word per cycle while out_ready is held at 1.
REQ-022 SHALL assert the first out_valid on the edge after the one that samples start.
REQ-023 SHALL compute the next pc from the loaded word: for opcode [31:26] equal to 2 or 3, next pc = instr[2:0]; otherwise next pc = pc+1, computed 4 bits wide.
REQ-024 SHALL set the end flag when the next pc equals DEPTH, or when fetch_count after the increment equals MAX_FETCH.
REQ-025 SHALL, with the end flag set, go to DONE on the edge where the last word is accepted; DONE means out_valid=0 and done=1.
REQ-026 SHALL ignore start while in RUN.
REQ-027 SHALL hold done=1 in DONE until start or rst.

Reset
REQ-028 SHALL, on rst asserted, immediately set state=IDLE, pc=0, out_valid=0, out_instr=0, out_pc=0, fetch_count=0, done=0 and the end flag=0.
REQ-029 SHALL discard an in-flight word when rst is asserted mid-RUN, with no acceptance counted.
REQ-030 SHALL not reset instruction memory contents.

Structure
REQ-031 SHALL place OP_J=2, OP_JAL=3, the DEPTH default and the FSM state typedef in a shared package.
REQ-032 SHALL use one sub-module, ins_rom: an 8x32 array with a synchronous write port and a combinational read port.

Verification
REQ-033 SHALL cover: load 8 non-jump words (0x20040056 at word 0), start, out_ready=1 -> out_pc 0..7 on 8 consecutive cycles, fetch_count=8, done=1 one cycle after the last accept.
REQ-034 SHALL cover: out_ready=0 for 3 cycles at word 2 -> out_instr and out_pc=2 held stable, no skipped or duplicated words, fetch_count=8 at done.
REQ-035 SHALL cover: word 3=0x08000006 (J, target 6), others non-jump -> out_pc sequence 0,1,2,3,6,7, done with fetch_count=6.
REQ-036 SHALL cover: word 7=0x08000000 (J to 0) -> fetching wraps and stops at fetch_count=15, done=1, last out_pc=6.
REQ-037 SHALL cover: rst pulsed mid-run at out_pc=4 -> all outputs return to reset values at once; memory contents persist; start refetches word 0 with its original data.
REQ-038 SHALL cover: ld_en=1 during RUN writing 0xFFFFFFFF to word 5 -> ignored, word 5 is fetched with its original value.

Source files
------------

// File: rtl/ins_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: opcodes that redirect
// the pc, default memory depth and the fetch FSM state type.
package ins_fetch_pkg;

    localparam int ADDR_W        = 3;
    localparam int DATA_W        = 32;
    localparam int DEFAULT_DEPTH = 8;

    localparam logic [5:0] OP_J   = 6'd2;
    localparam logic [5:0] OP_JAL = 6'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ins_fetch_rom.sv
// Program store: synchronous write port used for loading, combinational
// read port addressed by the fetch pc. Contents survive reset.
module ins_rom
    import ins_fetch_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ins_fetch.sv
// Instruction fetch unit: streams words from a loadable program store to a
// ready/valid consumer, following J/JAL redirects, until end of memory or a fetch limit.
module ins_fetch
    import ins_fetch_pkg::*;
#(
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int MAX_FETCH = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic [3:0]        fetch_count,
    output logic              done
);

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic              end_flag;
    logic [DATA_W-1:0] rom_data;
    logic              rom_we;
    logic              slot_free;
    logic [3:0]        next_pc;
    logic [3:0]        fc_next;
    logic              end_next;

    ins_rom #(.DEPTH(DEPTH)) u_rom (
        .clk   (clk),
        .we    (rom_we),
        .waddr (ld_addr),
        .wdata (ld_data),
        .raddr (pc),
        .rdata (rom_data)
    );

    // next pc is one bit wider than pc so that stepping past the last word is visible
    always_comb begin
        rom_we    = (state == IDLE) && ld_en;
        slot_free = !out_valid || out_ready;
        fc_next   = fetch_count + 4'd1;
        if (rom_data[31:26] == OP_J || rom_data[31:26] == OP_JAL) begin
            next_pc = {1'b0, rom_data[2:0]};
        end else begin
            next_pc = {1'b0, pc} + 4'd1;
        end
        end_next = (next_pc == 4'(DEPTH)) || (fc_next == 4'(MAX_FETCH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= '0;
            end_flag    <= 1'b0;
            out_valid   <= 1'b0;
            out_instr   <= '0;
            out_pc      <= '0;
            fetch_count <= '0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= RUN;
                        pc          <= '0;
                        end_flag    <= 1'b0;
                        out_valid   <= 1'b0;
                        fetch_count <= '0;
                        done        <= 1'b0;
                    end
                end
                RUN: begin
                    // with end_flag set, a free slot means the final word was just taken
                    if (slot_free) begin
                        if (!end_flag) begin
                            out_instr   <= rom_data;
                            out_pc      <= pc;
                            out_valid   <= 1'b1;
                            fetch_count <= fc_next;
                            pc          <= next_pc[ADDR_W-1:0];
                            end_flag    <= end_next;
                        end else begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
